kc_kbd_tx: RTL and testbench
============================

# kc_kbd_tx

Keyboard transmitter for the KC85/4 core. Consumes the `ps2_key` event word delivered by `hps_io` and emits the KC85/4 remote-keyboard serial pulse train, pulse-distance coded, on a single active-low line. That line drives the keyboard input of the CTC/PIO inside `kc854`. The block tracks the held key and shift state, maps PS/2 scancodes to 7-bit KC key codes, and auto-repeats while a key is held, as the original keyboard IC does.

## Interface
- `CLK_HZ`, default 50_000_000: clk_sys frequency; sets the 1 µs prescaler (CLK_HZ/1_000_000 − 1).
- `PULSE_US`, default 14: low-pulse width.
- `BIT0_US`, default 5120: pulse-to-pulse period for a 0 bit.
- `BIT1_US`, default 7168: pulse-to-pulse period for a 1 bit.
- `GAP_US`, default 19456: idle time after a word's final pulse before a repeat may start.
- `clk_sys` input 1: system clock; all logic on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `ps2_key` input 11: [10] toggle per event, [9] pressed, [8] extended, [7:0] scancode.
- `kbd_n` output 1: serial keyboard line, idle high, pulses low.
- `busy` output 1: high from the first pulse through the end of the gap.
- `key_held` output 1: a mapped key is currently pressed.
- `kc_code` output 7: code of the held or last sent key.

## Operation
- **Event capture:** register `ps2_key[10]`. A change marks a new event, with at most one event per clock.
- **Shift keys:** scancodes 0x12 and 0x59 (non-extended) set or clear `shift_l`/`shift_r`. They are never transmitted.
- **Key mapping:** other keys go through `kc_keymap({ext, shift, scancode})`, which returns `{valid, code[6:0]}`. If `valid=0`, the event is ignored.
- **Press of a mapped key:** `hold_code <= code`, `key_held <= 1`. A new press replaces the previous held key (last key wins).
- **Release:**
  - Matching the held scancode or extended flag: `key_held <= 0`.
  - Of a non-held key: ignored.
- **FSM states:** IDLE, PULSE, SPACE, GAP.
  - **IDLE:** if `key_held`, load shift register with `hold_code`, set bit index 0, go to PULSE.
  - **PULSE:** `kbd_n=0` for PULSE_US, then:
    - if index < 7: go to SPACE;
    - else (final pulse, the 8th): go to GAP.
  - **SPACE:** `kbd_n=1` until (BITx_US − PULSE_US) has elapsed since pulse end. BITx is selected by the current bit, LSB first. Then index+1, go to PULSE.
  - **GAP:** `kbd_n=1` for GAP_US, then go to IDLE.
- **Word shape:** 8 pulses delimit 7 data bits.
- **Auto-repeat:** IDLE re-evaluates `key_held` after every GAP, so a held key repeats indefinitely.
- **Code sampling:** the code is latched at word start. A new press mid-word does not alter the word in flight; the next word uses the new code.
- **Release mid-word:** the word completes, including GAP. No further word is sent.
- **Fast tap:** press and release between words still yields exactly one word. A pending flag is set on press and cleared at word start.
- **Shift timing:** a shift change while a key is held does not re-map until the next press.

## Timing
- **Reset values:** `kbd_n=1`, `busy=0`, `key_held=0`, `kc_code=0`, FSM=IDLE, shift flags 0, prescaler 0, toggle register 0.
- **Start latency:** from the toggle change to the first `kbd_n` falling edge is 3 clk_sys cycles: capture, map, then IDLE→PULSE registered.
- **Timebase:** durations are counted in 1 µs ticks from the free-running prescaler. The phase counter resets at each state entry.
- **Tolerance:** each state's duration is within +1 µs of nominal.
- **Word length:** 8·PULSE_US + Σ(BITx_US − PULSE_US) over the 7 bits, plus GAP_US.
- **Outputs:** `kbd_n` is a register output, glitch-free.
- **Reset mid-word:** `kbd_n` returns high immediately (async). The word is dropped, with no partial resume.

## Structure
- **Package `kc_kbd_pkg`:**
  - FSM state enum;
  - shift scancodes 0x12/0x59;
  - the keymap constant array (512 entries × 8 bits, indexed {shift, scancode} for non-extended, plus a small extended table).
- **Sub-module `kc_keymap`:** combinational ROM lookup, registered at its output. It is reused by a later keyboard overlay.
- **Decided entries:**
  - 0x5A Enter → 7'h12;
  - 0x29 Space → 7'h46;
  - 0x1C A unshifted → 7'h20, shifted → 7'h21;
  - E0 0x75 Up → 7'h78.

## Test plan
- **Enter:** toggle, pressed, 0x5A, then release after 100 ms.
  - Exactly 8 low pulses of 14 µs.
  - Spacings encode 7'h12 LSB first: 0,1,0,0,1,0,0 → periods 5120, 7168, 5120, 5120, 7168, 5120, 5120 µs.
  - Repeats while held; none after the word in flight at release completes.
- **Shift:** press 0x12, then press 0x1C → the word carries 7'h21. Release 0x12, then re-press 0x1C → 7'h21 then 7'h20.
- **Unmapped key:** scancode 0x00 pressed → `kbd_n` stays 1, `busy` stays 0.
- **Mid-word replacement:** press Space, then during bit 3 of its word press Up → the current word completes as 7'h46, the next word is 7'h78, and `kc_code`=7'h78.
- **Fast tap:** press and release 0x5A within 10 clocks → exactly one word, then idle.
- **Reset mid-word:** assert `reset_n=0` during a PULSE → `kbd_n`=1 within the same cycle. After release, there is no output until the next press.

Source files
------------

// File: rtl/kc_kbd_pkg.sv
// Shared types and key tables for the KC85/4 keyboard transmitter and keyboard overlay.
package kc_kbd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_SPACE,
        ST_GAP
    } tx_state_t;

    localparam logic [7:0] SC_SHIFT_L = 8'h12;
    localparam logic [7:0] SC_SHIFT_R = 8'h59;

    // Non-extended map: index {shift, scancode}, entry {valid, code[6:0]}
    typedef logic [511:0][7:0] keymap_t;

    function automatic keymap_t build_keymap();
        keymap_t m;
        m = '0;
        m[{1'b0, 8'h5A}] = {1'b1, 7'h12};
        m[{1'b1, 8'h5A}] = {1'b1, 7'h12};
        m[{1'b0, 8'h29}] = {1'b1, 7'h46};
        m[{1'b1, 8'h29}] = {1'b1, 7'h46};
        m[{1'b0, 8'h1C}] = {1'b1, 7'h20};
        m[{1'b1, 8'h1C}] = {1'b1, 7'h21};
        return m;
    endfunction

    localparam keymap_t KEYMAP = build_keymap();

    // Extended (E0-prefixed) keys: small search table
    localparam int EXT_N = 2;
    localparam logic [EXT_N-1:0][7:0] EXT_SC  = {8'h5A, 8'h75};
    localparam logic [EXT_N-1:0][7:0] EXT_ENT = {8'h92, 8'hF8};

endpackage

// File: rtl/kc_keymap.sv
// PS/2 scancode to KC key code lookup.
// Latency: 1 clk_sys (registered output).
// Backpressure: none, a new lookup may be issued every cycle.
module kc_keymap
    import kc_kbd_pkg::*;
(
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ext,
    input  logic       shift,
    input  logic [7:0] scancode,
    output logic       valid,
    output logic [6:0] code
);

    logic [7:0] ent;

    always_comb begin
        ent = KEYMAP[{shift, scancode}];
        if (ext) begin
            ent = '0;
            for (int i = 0; i < EXT_N; i++) begin
                if (EXT_SC[i] == scancode)
                    ent = EXT_ENT[i];
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            code  <= '0;
        end else begin
            valid <= ent[7];
            code  <= ent[6:0];
        end
    end

endmodule

// File: rtl/kc_kbd_tx.sv
// KC85/4 remote keyboard transmitter: ps2_key events to pulse-distance coded kbd_n.
// Latency: 3 clk_sys from toggle change to first kbd_n fall (capture, map, start).
// Backpressure: none; presses during a word are held as pending and sent next.
module kc_kbd_tx
    import kc_kbd_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int PULSE_US = 14,
    parameter int BIT0_US  = 5120,
    parameter int BIT1_US  = 7168,
    parameter int GAP_US   = 19456
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    output logic        kbd_n,
    output logic        busy,
    output logic        key_held,
    output logic [6:0]  kc_code
);

    localparam int PRE_MAX = CLK_HZ / 1_000_000 - 1;
    localparam int PRE_W   = $clog2(PRE_MAX + 2);
    localparam int US_W    = $clog2(GAP_US + BIT1_US + BIT0_US + 2);

    localparam logic [US_W-1:0] D_PULSE = US_W'(PULSE_US);
    localparam logic [US_W-1:0] D_SP0   = US_W'(BIT0_US - PULSE_US);
    localparam logic [US_W-1:0] D_SP1   = US_W'(BIT1_US - PULSE_US);
    localparam logic [US_W-1:0] D_GAP   = US_W'(GAP_US);

    logic [PRE_W-1:0] pre_cnt;
    logic             us_tick;

    assign us_tick = (pre_cnt == PRE_W'(PRE_MAX));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) pre_cnt <= '0;
        else          pre_cnt <= us_tick ? '0 : pre_cnt + 1'b1;
    end

    // Capture stage; the first cycle after reset only samples the toggle
    logic       armed, tog_q, cap_vld, cap_pressed, cap_ext;
    logic [7:0] cap_sc;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            armed       <= 1'b0;
            tog_q       <= 1'b0;
            cap_vld     <= 1'b0;
            cap_pressed <= 1'b0;
            cap_ext     <= 1'b0;
            cap_sc      <= '0;
        end else begin
            armed       <= 1'b1;
            tog_q       <= ps2_key[10];
            cap_vld     <= armed & (ps2_key[10] ^ tog_q);
            cap_pressed <= ps2_key[9];
            cap_ext     <= ps2_key[8];
            cap_sc      <= ps2_key[7:0];
        end
    end

    // Map stage
    logic       shift_l, shift_r, is_shift, map_valid;
    logic       map_vld, map_pressed, map_ext;
    logic [7:0] map_sc;
    logic [6:0] map_code;

    assign is_shift = !cap_ext && (cap_sc == SC_SHIFT_L || cap_sc == SC_SHIFT_R);

    kc_keymap u_keymap (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ext      (cap_ext),
        .shift    (shift_l | shift_r),
        .scancode (cap_sc),
        .valid    (map_valid),
        .code     (map_code)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            shift_l     <= 1'b0;
            shift_r     <= 1'b0;
            map_vld     <= 1'b0;
            map_pressed <= 1'b0;
            map_ext     <= 1'b0;
            map_sc      <= '0;
        end else begin
            if (cap_vld && is_shift && cap_sc == SC_SHIFT_L) shift_l <= cap_pressed;
            if (cap_vld && is_shift && cap_sc == SC_SHIFT_R) shift_r <= cap_pressed;
            map_vld     <= cap_vld & ~is_shift;
            map_pressed <= cap_pressed;
            map_ext     <= cap_ext;
            map_sc      <= cap_sc;
        end
    end

    // Held-key state
    logic       press_now, release_now, pending, start, hold_ext;
    logic [7:0] hold_sc;
    tx_state_t  state;

    assign press_now   = map_vld & map_pressed & map_valid;
    assign release_now = map_vld & ~map_pressed & key_held &
                         ({map_ext, map_sc} == {hold_ext, hold_sc});
    assign start       = (state == ST_IDLE) & (key_held | pending | press_now);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            key_held <= 1'b0;
            kc_code  <= '0;
            hold_ext <= 1'b0;
            hold_sc  <= '0;
            pending  <= 1'b0;
        end else begin
            if (press_now) begin
                key_held <= 1'b1;
                kc_code  <= map_code;
                hold_ext <= map_ext;
                hold_sc  <= map_sc;
            end else if (release_now) begin
                key_held <= 1'b0;
            end
            if (start)          pending <= 1'b0;
            else if (press_now) pending <= 1'b1;
        end
    end

    // Serialiser: 8 pulses, each space after pulse i carries bit i (LSB first)
    logic [6:0]      shreg;
    logic [2:0]      bit_idx;
    logic [US_W-1:0] us_cnt, sp_dur;

    assign sp_dur = shreg[0] ? D_SP1 : D_SP0;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            kbd_n   <= 1'b1;
            busy    <= 1'b0;
            shreg   <= '0;
            bit_idx <= '0;
            us_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shreg   <= press_now ? map_code : kc_code;
                        bit_idx <= '0;
                        us_cnt  <= '0;
                        kbd_n   <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (us_tick) begin
                        if (us_cnt == D_PULSE) begin
                            us_cnt <= '0;
                            kbd_n  <= 1'b1;
                            state  <= (bit_idx == 3'd7) ? ST_GAP : ST_SPACE;
                        end else begin
                            us_cnt <= us_cnt + 1'b1;
                        end
                    end
                end
                ST_SPACE: begin
                    if (us_tick) begin
                        if (us_cnt == sp_dur) begin
                            us_cnt  <= '0;
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 3'd1;
                            kbd_n   <= 1'b0;
                            state   <= ST_PULSE;
                        end else begin
                            us_cnt <= us_cnt + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (us_tick) begin
                        if (us_cnt == D_GAP) begin
                            us_cnt <= '0;
                            busy   <= 1'b0;
                            state  <= ST_IDLE;
                        end else begin
                            us_cnt <= us_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kc_kbd_tx.sv
// Directed bench for kc_kbd_tx with a pulse-train decoder and an expected-code queue.
module tb_kc_kbd_tx;

    localparam int CLK_HZ   = 4_000_000;
    localparam int US_C     = CLK_HZ / 1_000_000;
    localparam int PULSE_US = 2;
    localparam int BIT0_US  = 6;
    localparam int BIT1_US  = 10;
    localparam int GAP_US   = 12;
    localparam int THR      = (BIT0_US + BIT1_US + 2) * US_C / 2;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic        kbd_n, busy, key_held;
    logic [6:0]  kc_code;
    logic        tog;

    kc_kbd_tx #(
        .CLK_HZ   (CLK_HZ),
        .PULSE_US (PULSE_US),
        .BIT0_US  (BIT0_US),
        .BIT1_US  (BIT1_US),
        .GAP_US   (GAP_US)
    ) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ps2_key  (ps2_key),
        .kbd_n    (kbd_n),
        .busy     (busy),
        .key_held (key_held),
        .kc_code  (kc_code)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [6:0] code;
        int         width_bad;
        int         period_bad;
        int         gap_bad;
    } word_t;

    word_t      rx_words[$];
    logic [6:0] exp_q[$];
    int         rx_rd = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    // Decoder: measures low widths, pulse periods and inter-word gaps
    int         cyc = 0, mon_npulse = 0, mon_falls = 0, mon_busy = 0;
    int         last_fall = 0, last_rise = 0, per = 0, wid = 0;
    int         wbad = 0, pbad = 0, gbad = 0;
    logic       prev_n = 1'b1, have_rise = 1'b0, bitv;
    logic [6:0] acc = '0;
    word_t      wtmp;

    initial begin
        forever begin
            @(negedge clk_sys);
            cyc++;
            if (!reset_n) begin
                mon_npulse = 0; prev_n = 1'b1; acc = '0;
                wbad = 0; pbad = 0; gbad = 0; have_rise = 1'b0;
            end else begin
                if (busy) mon_busy++;
                if (prev_n && !kbd_n) begin
                    mon_falls++;
                    if (mon_npulse == 0) begin
                        if (have_rise && (cyc - last_rise) < GAP_US * US_C) gbad++;
                    end else begin
                        per  = cyc - last_fall;
                        bitv = (per > THR);
                        if (bitv && (per < BIT1_US * US_C || per > (BIT1_US + 2) * US_C)) pbad++;
                        if (!bitv && (per < BIT0_US * US_C || per > (BIT0_US + 2) * US_C)) pbad++;
                        acc[mon_npulse-1] = bitv;
                    end
                    last_fall = cyc;
                    mon_npulse++;
                end else if (!prev_n && kbd_n) begin
                    wid = cyc - last_fall;
                    if (wid < PULSE_US * US_C || wid > (PULSE_US + 1) * US_C) wbad++;
                    last_rise = cyc;
                    have_rise = 1'b1;
                    if (mon_npulse == 8) begin
                        wtmp.code = acc; wtmp.width_bad = wbad;
                        wtmp.period_bad = pbad; wtmp.gap_bad = gbad;
                        rx_words.push_back(wtmp);
                        mon_npulse = 0; wbad = 0; pbad = 0; gbad = 0; acc = '0;
                    end
                end
                prev_n = kbd_n;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic pressed, input logic ext, input logic [7:0] sc);
        @(posedge clk_sys); #1;
        tog     = ~tog;
        ps2_key = {tog, pressed, ext, sc};
    endtask

    task automatic wait_fall(input string tag);
        int n = 0;
        @(posedge clk_sys); #1;
        while (kbd_n !== 1'b0 && n < 2000) begin
            @(posedge clk_sys); #1;
            n++;
        end
        check(tag, kbd_n, 1'b0);
    endtask

    task automatic expect_word(input string tag);
        int         n = 0;
        logic [6:0] e;
        while (rx_words.size() <= rx_rd && n < 3000) begin
            @(posedge clk_sys);
            n++;
        end
        #1;
        check({tag, " arrived"}, rx_words.size() > rx_rd, 1);
        if (rx_words.size() > rx_rd) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 7'h7f;
            check({tag, " code"}, rx_words[rx_rd].code, e);
            check({tag, " width"}, rx_words[rx_rd].width_bad, 0);
            check({tag, " period"}, rx_words[rx_rd].period_bad, 0);
            check({tag, " gap"}, rx_words[rx_rd].gap_bad, 0);
            rx_rd++;
        end
    endtask

    task automatic idle_check(input string tag, input int cycles);
        int f0 = mon_falls;
        repeat (cycles) @(posedge clk_sys);
        #1;
        check({tag, " no pulses"}, mon_falls - f0, 0);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " queue"}, exp_q.size(), 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, b0, n;
        reset_n = 1'b0;
        tog     = 1'b0;
        ps2_key = '0;
        repeat (3) @(posedge clk_sys);
        #1;
        check("rst kbd_n", kbd_n, 1'b1);
        check("rst busy", busy, 1'b0);
        check("rst key_held", key_held, 1'b0);
        check("rst kc_code", kc_code, 7'h00);
        reset_n = 1'b1;
        repeat (3) @(posedge clk_sys);

        // Enter: start latency, three repeated words, release during the third
        send(1'b1, 1'b0, 8'h5A);
        repeat (2) @(posedge clk_sys);
        #1;
        check("lat2 kbd_n high", kbd_n, 1'b1);
        @(posedge clk_sys); #1;
        check("lat3 kbd_n low", kbd_n, 1'b0);
        check("lat3 busy", busy, 1'b1);
        check("enter key_held", key_held, 1'b1);
        check("enter kc_code", kc_code, 7'h12);
        repeat (3) exp_q.push_back(7'h12);
        expect_word("enter w1");
        expect_word("enter w2");
        wait_fall("enter w3 start");
        send(1'b0, 1'b0, 8'h5A);
        expect_word("enter w3");
        check("enter released", key_held, 1'b0);
        idle_check("enter idle", 800);

        // Unmapped scancode
        f0 = mon_falls;
        b0 = mon_busy;
        send(1'b1, 1'b0, 8'h00);
        repeat (300) @(posedge clk_sys);
        #1;
        check("unmapped pulses", mon_falls - f0, 0);
        check("unmapped busy", mon_busy - b0, 0);
        check("unmapped held", key_held, 1'b0);
        send(1'b0, 1'b0, 8'h00);

        // Shift: shifted A, shift released mid-hold, A re-pressed then released
        send(1'b1, 1'b0, 8'h12);
        send(1'b1, 1'b0, 8'h1C);
        exp_q.push_back(7'h21);
        wait_fall("shift word start");
        send(1'b0, 1'b0, 8'h12);
        send(1'b1, 1'b0, 8'h1C);
        exp_q.push_back(7'h20);
        send(1'b0, 1'b0, 8'h1C);
        expect_word("shift A");
        expect_word("unshift A");
        check("unshift kc_code", kc_code, 7'h20);
        idle_check("shift idle", 800);

        // Space replaced by Up during bit 3
        send(1'b1, 1'b0, 8'h29);
        exp_q.push_back(7'h46);
        n = 0;
        while (mon_npulse != 4 && n < 2000) begin
            @(posedge clk_sys);
            n++;
        end
        #1;
        check("space bit3 reached", mon_npulse, 4);
        send(1'b1, 1'b1, 8'h75);
        exp_q.push_back(7'h78);
        expect_word("space");
        check("up kc_code", kc_code, 7'h78);
        send(1'b0, 1'b0, 8'h29);
        repeat (4) @(posedge clk_sys);
        #1;
        check("space release ignored", key_held, 1'b1);
        send(1'b0, 1'b1, 8'h75);
        expect_word("up");
        idle_check("up idle", 800);

        // Fast tap
        send(1'b1, 1'b0, 8'h5A);
        exp_q.push_back(7'h12);
        repeat (5) @(posedge clk_sys);
        send(1'b0, 1'b0, 8'h5A);
        expect_word("tap");
        idle_check("tap idle", 800);

        // Reset during a pulse drops the word
        send(1'b1, 1'b0, 8'h1C);
        wait_fall("rst word start");
        #2;
        reset_n = 1'b0;
        #1;
        check("async rst kbd_n", kbd_n, 1'b1);
        check("async rst busy", busy, 1'b0);
        check("async rst held", key_held, 1'b0);
        check("async rst kc_code", kc_code, 7'h00);
        repeat (3) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        f0 = mon_falls;
        repeat (800) @(posedge clk_sys);
        #1;
        check("post rst silent", mon_falls - f0, 0);
        check("post rst no words", rx_words.size() - rx_rd, 0);
        send(1'b0, 1'b0, 8'h1C);

        send(1'b1, 1'b0, 8'h5A);
        exp_q.push_back(7'h12);
        repeat (3) @(posedge clk_sys);
        send(1'b0, 1'b0, 8'h5A);
        expect_word("post rst press");
        idle_check("final idle", 800);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
